// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types, funct3 encodings and access-size helper for the load/store unit.
package rv32i_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RESP} lsu_state_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 3'd1 : (sz == 2'b01) ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: sign/zero-extends the assembled load bytes to a 32-bit register value.
module lsu_load_extend
  import rv32i_pkg::*;
(
  input  logic [31:0] asm_data,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);
  assign data = (size == F3_LB[1:0]) ? {{24{~is_unsigned & asm_data[7]}}, asm_data[7:0]} :
                (size == F3_LH[1:0]) ? {{16{~is_unsigned & asm_data[15]}}, asm_data[15:0]} :
                asm_data;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: issues RV32I loads/stores to generic_memory, splitting misaligned
// accesses into byte ops and returning extended load data with an error flag.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int MEM_WIDTH      = 15,
  parameter int MLEN           = 64,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [2:0]           mem_funct3,
  output logic [MEM_WIDTH-1:0] mem_rd_addr,
  input  logic [MLEN-1:0]      mem_rd_data,
  output logic [MEM_WIDTH-1:0] mem_wr_addr,
  output logic [MLEN-1:0]      mem_wr_data,
  output logic                 mem_wr_en,
  input  logic [1:0]           mem_error
);
  lsu_state_t state_q, state_d;
  logic we_q, we_d, split_q, split_d, err_q, err_d, pend_q, pend_d;
  logic [2:0] f3_q, f3_d, k_q, k_d, n_q, n_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, asm_q, asm_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d, ext, sz_mask;
  logic [2:0] bytes;
  logic [1:0] op_sz;
  logic [MEM_WIDTH-1:0] op_addr;
  logic issue, illegal, misaligned, bad, store_fail, unused_rd;
  assign bytes      = size_bytes(f3_q[1:0]);
  assign op_sz      = split_q ? 2'b00 : f3_q[1:0];
  assign sz_mask    = (op_sz == 2'b00) ? 32'h0000_00ff : (op_sz == 2'b01) ? 32'h0000_ffff : 32'hffff_ffff;
  assign op_addr    = addr_q[MEM_WIDTH-1:0] + MEM_WIDTH'(k_q);
  assign issue      = state_q == S_ISSUE;
  assign illegal    = we_q ? (f3_q > F3_SW) : (f3_q == 3'b011 || f3_q[2:1] == 2'b11);
  assign misaligned = |(addr_q[1:0] & (bytes[1:0] - 2'd1));
  assign bad        = illegal | (|addr_q[31:MEM_WIDTH]) | (misaligned & ~MISALIGN_SPLIT);
  // A store's write error arrives the cycle after its strobe; it also blocks the next strobe.
  assign store_fail = pend_q & mem_error[1];
  assign unused_rd  = ^mem_rd_data[MLEN-1:32];
  assign req_ready   = (state_q == S_IDLE) & ~rsp_valid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign mem_funct3  = issue ? {~we_q, op_sz} : 3'b000;
  assign mem_rd_addr = (issue & ~we_q) ? op_addr : '0;
  assign mem_wr_addr = (issue & we_q) ? op_addr : '0;
  assign mem_wr_data = (issue & we_q) ? MLEN'((wdata_q >> {k_q[1:0], 3'b000}) & sz_mask) : '0;
  assign mem_wr_en   = issue & we_q & ~store_fail;
  lsu_load_extend u_ext (
    .asm_data   (asm_q),
    .size       (f3_q[1:0]),
    .is_unsigned(f3_q[2]),
    .data       (ext)
  );
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    k_d         = k_q;
    n_d         = n_q;
    split_d     = split_q;
    err_d       = err_q;
    pend_d      = pend_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      S_IDLE: if (req_valid && req_ready) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        asm_d   = '0;
        k_d     = '0;
        err_d   = 1'b0;
        pend_d  = 1'b0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        split_d = misaligned;
        n_d     = misaligned ? bytes : 3'd1;
        err_d   = bad;
        state_d = bad ? S_RESP : S_ISSUE;
      end
      S_ISSUE: if (store_fail) begin
        err_d   = 1'b1;
        pend_d  = 1'b0;
        state_d = S_RESP;
      end else if (we_q) begin
        pend_d  = 1'b1;
        k_d     = k_q + 3'd1;
        state_d = (k_q + 3'd1 == n_q) ? S_RESP : S_ISSUE;
      end else begin
        state_d = S_WAIT;
      end
      S_WAIT: if (mem_error[0]) begin
        err_d   = 1'b1;
        state_d = S_RESP;
      end else begin
        asm_d   = split_q ? (asm_q | ({24'b0, mem_rd_data[7:0]} << {k_q[1:0], 3'b000}))
                          : (mem_rd_data[31:0] & sz_mask);
        k_d     = k_q + 3'd1;
        state_d = (k_q + 3'd1 == n_q) ? S_RESP : S_ISSUE;
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q | store_fail;
        rsp_rdata_d = (we_q | err_q | store_fail) ? 32'h0 : ext;
        pend_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      k_q         <= '0;
      n_q         <= '0;
      split_q     <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      k_q         <= k_d;
      n_q         <= n_d;
      split_q     <= split_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table, reset/no-split corner cases and random ops
// checked against an ideal byte-addressed memory model.
module tb_load_store_unit;
  localparam int MW = 15;
  localparam int MLEN = 64;
  localparam int MSZ = 1 << MW;
  logic clk = 1'b0, aresetn = 1'b0;
  logic req_valid = 1'b0, req_valid2 = 1'b0, req_we = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, mem_wr_en;
  logic [31:0] rsp_rdata;
  logic [2:0] mem_funct3;
  logic [MW-1:0] mem_rd_addr, mem_wr_addr;
  logic [MLEN-1:0] mem_rd_data = '0, mem_wr_data;
  logic [1:0] mem_error = '0;
  logic req_ready2, rsp_valid2, rsp_err2, mem_wr_en2;
  logic [31:0] rsp_rdata2;
  logic [2:0] mem_funct3_2;
  logic [MW-1:0] rd_addr2, wr_addr2;
  logic [MLEN-1:0] wr_data2, zero64 = '0;
  logic [1:0] zero2 = '0;
  bit [7:0] mem [MSZ];
  bit [7:0] ref_mem [MSZ];
  bit inj = 1'b0;
  int rd_cnt = 0;
  int wr_log[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WIDTH(MW), .MLEN(MLEN), .MISALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_funct3(mem_funct3), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_error(mem_error)
  );

  load_store_unit #(.MEM_WIDTH(MW), .MLEN(MLEN), .MISALIGN_SPLIT(1'b0)) u_ns (
    .clk(clk), .aresetn(aresetn), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
    .mem_funct3(mem_funct3_2), .mem_rd_addr(rd_addr2), .mem_rd_data(zero64),
    .mem_wr_addr(wr_addr2), .mem_wr_data(wr_data2), .mem_wr_en(mem_wr_en2),
    .mem_error(zero2)
  );

  // Bench-side generic_memory: synchronous read, write at posedge, registered error flags.
  always @(posedge clk) begin
    if (mem_wr_en) begin
      for (int i = 0; i < (1 << mem_funct3[1:0]); i++)
        mem[(int'(mem_wr_addr) + i) % MSZ] <= mem_wr_data[8*i +: 8];
      wr_log.push_back(int'(mem_wr_addr));
    end
    if (mem_funct3[2]) rd_cnt++;
    for (int i = 0; i < 8; i++) mem_rd_data[8*i +: 8] <= mem[(int'(mem_rd_addr) + i) % MSZ];
    mem_error <= {mem_wr_en & inj, mem_funct3[2] & inj};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit inj_i, output logic [31:0] rd,
                       output logic err, output int lat, output int nops);
    int guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 32'd1);
    inj = inj_i;
    wr_log.delete();
    rd_cnt = 0;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1; lat++;
      if (rsp_valid) break;
    end
    rd = rsp_rdata;
    err = rsp_err;
    nops = we ? wr_log.size() : rd_cnt;
    inj = 1'b0;
  endtask

  // Ideal memory semantics: legality, range, sizes, extension and latency from the rules.
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input bit inj_i, input bit split,
                                output logic [31:0] rd, output logic err, output int lat,
                                output int nops);
    int bytes, n;
    logic [31:0] v;
    bytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    rd = 0; err = 1'b1; lat = 2; nops = 0;
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return;
    if (a >= 32'(MSZ)) return;
    n = (a % 32'(bytes) != 0) ? bytes : 1;
    if (n > 1 && !split) return;
    nops = inj_i ? 1 : n;
    err = inj_i;
    if (we) begin
      for (int i = 0; i < bytes; i++)
        if (!inj_i || n == 1 || i == 0) ref_mem[(int'(a) + i) % MSZ] = wd[8*i +: 8];
      lat = inj_i ? ((n > 1) ? 4 : 3) : 2 + n;
    end else begin
      v = 0;
      for (int i = 0; i < bytes; i++) v = v | (32'(ref_mem[(int'(a) + i) % MSZ]) << (8 * i));
      if (bytes < 4 && !f3[2] && v[8*bytes-1]) v = v | (32'hffff_ffff << (8 * bytes));
      lat = inj_i ? 4 : 2 + 2 * n;
      rd = inj_i ? 32'h0 : v;
    end
  endfunction

  typedef struct {
    bit we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] exp_rd; bit exp_err; int exp_lat; int exp_nops;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] rd, m_rd;
    logic err, m_err;
    int lat, nops, m_lat, m_nops, guard, bad;
    bit seen;
    logic [2:0] ll[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    vecs.push_back('{1, 3'd2, 32'h100,   32'hDEADBEEF, 32'h0,        0, 3, 1});
    vecs.push_back('{0, 3'd2, 32'h100,   32'h0,        32'hDEADBEEF, 0, 4, 1});
    vecs.push_back('{1, 3'd0, 32'h203,   32'h80,       32'h0,        0, 3, 1});
    vecs.push_back('{0, 3'd0, 32'h203,   32'h0,        32'hFFFFFF80, 0, 4, 1});
    vecs.push_back('{0, 3'd4, 32'h203,   32'h0,        32'h00000080, 0, 4, 1});
    vecs.push_back('{1, 3'd2, 32'h105,   32'h11223344, 32'h0,        0, 6, 4});
    vecs.push_back('{0, 3'd2, 32'h105,   32'h0,        32'h11223344, 0, 10, 4});
    vecs.push_back('{0, 3'd1, 32'h107,   32'h0,        32'h00001122, 0, 6, 2});
    vecs.push_back('{0, 3'd1, 32'h106,   32'h0,        32'h00002233, 0, 4, 1});
    vecs.push_back('{0, 3'd3, 32'h10000, 32'h0,        32'h0,        1, 2, 0});
    vecs.push_back('{1, 3'd3, 32'h100,   32'h5,        32'h0,        1, 2, 0});
    vecs.push_back('{0, 3'd2, 32'h10000, 32'h0,        32'h0,        1, 2, 0});
    vecs.push_back('{1, 3'd1, 32'h7FFF,  32'h1234BEEF, 32'h0,        0, 4, 2});
    vecs.push_back('{0, 3'd1, 32'h7FFF,  32'h0,        32'hFFFFBEEF, 0, 6, 2});
    vecs.push_back('{0, 3'd5, 32'h7FFF,  32'h0,        32'h0000BEEF, 0, 6, 2});
    vecs.push_back('{1, 3'd1, 32'h302,   32'hA5A51234, 32'h0,        0, 3, 1});
    vecs.push_back('{0, 3'd2, 32'h300,   32'h0,        32'h12340000, 0, 4, 1});
    vecs.push_back('{0, 3'd6, 32'h300,   32'h0,        32'h0,        1, 2, 0});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
    chk("rst_mem_funct3", {29'b0, mem_funct3}, 32'd0);
    chk("rst_mem_wr_addr", 32'(mem_wr_addr), 32'd0);
    aresetn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b0, rd, err, lat, nops);
      model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b0, 1'b1, m_rd, m_err, m_lat, m_nops);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_mem_ops", i), nops, vecs[i].exp_nops);
      chk($sformatf("vec%0d_ready_busy", i), {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rsp_pulse", i), {31'b0, rsp_valid}, 32'd0);
      chk($sformatf("vec%0d_ready_back", i), {31'b0, req_ready}, 32'd1);
    end

    // No-split instance: misaligned halfword load errors out without touching memory.
    req_we = 1'b0; req_funct3 = 3'd1; req_addr = 32'h101; req_wdata = 0; req_valid2 = 1'b1;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    lat = 0; seen = 1'b0;
    while (lat < 20) begin
      @(posedge clk); #1; lat++;
      if (mem_wr_en2 || mem_funct3_2 != 3'd0) seen = 1'b1;
      if (rsp_valid2) break;
    end
    chk("nosplit_err", {31'b0, rsp_err2}, 32'd1);
    chk("nosplit_rdata", rsp_rdata2, 32'd0);
    chk("nosplit_latency", lat, 32'd2);
    chk("nosplit_mem_touched", {31'b0, seen}, 32'd0);

    // Reset in the middle of a split store, after two byte writes have committed.
    wr_log.delete();
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h405; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (wr_log.size() < 2 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    chk("rstmid_two_writes", wr_log.size(), 32'd2);
    aresetn = 1'b0;
    #1;
    chk("rstmid_wr_en_low", {31'b0, mem_wr_en}, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    aresetn = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("rstmid_no_rsp", {31'b0, seen}, 32'd0);
    chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
    chk("rstmid_write_count", wr_log.size(), 32'd2);
    ref_mem[16'h405] = 8'h0D;
    ref_mem[16'h406] = 8'hF0;
    do_op(1'b0, 3'd2, 32'h404, 32'h0, 1'b0, rd, err, lat, nops);
    model(1'b0, 3'd2, 32'h404, 32'h0, 1'b0, 1'b1, m_rd, m_err, m_lat, m_nops);
    chk("rstmid_readback", rd, m_rd);

    for (int t = 0; t < 3000; t++) begin
      bit we, inj_i;
      logic [2:0] f3;
      logic [31:0] a, wd;
      we = 1'($urandom % 2);
      f3 = ($urandom % 8 == 0) ? 3'($urandom % 8) : (we ? 3'($urandom % 3) : ll[$urandom % 5]);
      a = ($urandom % 8 == 0) ? $urandom : (32'h7F80 + ($urandom % 256)) % MSZ;
      wd = $urandom;
      inj_i = ($urandom % 16 == 0);
      do_op(we, f3, a, wd, inj_i, rd, err, lat, nops);
      model(we, f3, a, wd, inj_i, 1'b1, m_rd, m_err, m_lat, m_nops);
      chk($sformatf("rand%0d_rdata", t), rd, m_rd);
      chk($sformatf("rand%0d_err", t), {31'b0, err}, {31'b0, m_err});
      chk($sformatf("rand%0d_latency", t), lat, m_lat);
      chk($sformatf("rand%0d_mem_ops", t), nops, m_nops);
    end

    bad = 0;
    for (int i = 0; i < MSZ; i++) if (mem[i] != ref_mem[i]) bad++;
    chk("mem_image_diffs", bad, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
